// File: rtl/ram4_pkg.sv
// Shared encodings for the 4-bit counter RAM port-b initiator.
// Holds the op codes, the FSM state encoding and the RAM geometry constants.
// Pure declarations; no logic.
package ram4_pkg;

  localparam int RAM4_DEPTH  = 2140;
  localparam int RAM4_ADDR_W = 12;
  localparam int RAM4_DATA_W = 4;

  // Request opcodes as driven on req_op
  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_INC   = 2'd2;
  localparam logic [1:0] OP_DEC   = 2'd3;

  // FSM state encoding; kept as plain constants so older code can compare raw values
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD_ISSUE = 3'd1;
  localparam state_t ST_RD_WAIT  = 3'd2;
  localparam state_t ST_MODIFY   = 3'd3;
  localparam state_t ST_WR_ISSUE = 3'd4;
  localparam state_t ST_WR_WAIT  = 3'd5;
  localparam state_t ST_RESP     = 3'd6;

endpackage

// File: rtl/ram4_rmw_initiator_sat_addsub4.sv
// Saturating +1 / -1 on a small unsigned cell, with a flag when the limit blocks the step.
// Latency: purely combinational.
// Backpressure: none; result follows the inputs.
module sat_addsub4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] res_o,
  output logic         sat_o
);

  // At all-ones an increment saturates, at zero a decrement does; the value is then passed through
  always_comb begin
    sat_o = dec_i ? (val_i == '0) : (val_i == '1);
    if (sat_o) begin
      res_o = val_i;
    end else if (dec_i) begin
      res_o = val_i - W'(1);
    end else begin
      res_o = val_i + W'(1);
    end
  end

endmodule

// File: rtl/ram4_rmw_initiator.sv
// Port-b request initiator for the 4-bit counter RAM: read, write, saturating inc/dec with range check and timeout.
// Latency (RAM answering 3 cycles after enb): READ/WRITE 5, INC/DEC 10, saturated 6, out-of-range 1 cycle to rsp_valid.
// Backpressure: one request in flight, req_ready only in IDLE; responses cannot be stalled.
module ram4_rmw_initiator
  import ram4_pkg::*;
#(
  parameter int ADDR_W  = RAM4_ADDR_W,
  parameter int DATA_W  = RAM4_DATA_W,
  parameter int DEPTH   = RAM4_DEPTH,
  parameter int TIMEOUT = 15
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_sat,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dib,
  input  logic [DATA_W-1:0] dob,
  input  logic              dob_valid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last wait-cycle count before giving up: the counter holds 0 in the first wait cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              err_q, err_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] mod_res;
  logic              mod_sat;
  logic              addr_oor;
  logic              rd_phase;
  logic              wr_phase;

  // Saturating step on the value fetched from the RAM; direction comes from the latched op
  sat_addsub4 #(
    .W (DATA_W)
  ) u_sat (
    .val_i (val_q),
    .dec_i (op_q == OP_DEC),
    .res_o (mod_res),
    .sat_o (mod_sat)
  );

  assign addr_oor = 32'(req_addr) >= DEPTH;

  // Next-state and datapath: val_q carries write data, then the read value, then the modified value
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    val_d   = val_q;
    err_d   = err_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          addr_d = req_addr;
          val_d  = (req_op == OP_WRITE) ? req_data : '0;
          err_d  = 1'b0;
          sat_d  = 1'b0;
          cnt_d  = '0;
          if (addr_oor) begin
            // Bad address never reaches the RAM
            err_d   = 1'b1;
            val_d   = '0;
            state_d = ST_RESP;
          end else if (req_op == OP_WRITE) begin
            state_d = ST_WR_ISSUE;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (dob_valid) begin
          val_d   = dob;
          state_d = (op_q == OP_READ) ? ST_RESP : ST_MODIFY;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          val_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MODIFY: begin
        if (mod_sat) begin
          // Cell already at the limit: report it and leave the RAM untouched
          sat_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          val_d   = mod_res;
          state_d = ST_WR_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (dob_valid) begin
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          val_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured request; reset aborts any access in flight without a response
  always_ff @(posedge clka or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state so they are glitch-free and held through each wait
  always_comb begin
    rd_phase  = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);
    wr_phase  = (state_q == ST_WR_ISSUE) || (state_q == ST_WR_WAIT);
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_data  = rsp_valid ? val_q : '0;
    rsp_err   = rsp_valid & err_q;
    rsp_sat   = rsp_valid & sat_q;
    enb       = (state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE);
    web       = wr_phase;
    addrb     = (rd_phase || wr_phase) ? addr_q : '0;
    dib       = wr_phase ? val_q : '0;
  end

endmodule

// File: doc/ram4_rmw_initiator.md
Name: ram4_rmw_initiator

Overview:
- Request-side initiator for the 4-bit x 2140 dual-port counter RAM, driving its port b (enb/web/addrb/dib, returning dob/dob_valid).
- Accepts one request at a time from the sketch update pipeline: read, write, saturating increment or saturating decrement of a 4-bit cell.
- Performs RAM read-modify-write, checks address range, supervises the RAM handshake with a timeout, and returns one response pulse per request.
- At integration the RAM's clkb is tied to clka.

Parameters:
- ADDR_W, 12, address width.
- DATA_W, 4, cell width.
- DEPTH, 2140, number of valid cells; legal addresses 0..DEPTH-1.
- TIMEOUT, 15, maximum wait cycles for dob_valid per RAM access.

Ports:
- clka  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  0=READ, 1=WRITE, 2=INC, 3=DEC.
- req_addr  in  ADDR_W  cell address.
- req_data  in  DATA_W  write data; WRITE only.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  READ: stored value; WRITE: written value; INC/DEC: new value.
- rsp_err  out  1  out-of-range address or timeout.
- rsp_sat  out  1  INC at 15 or DEC at 0; cell value unchanged.
- enb  out  1  RAM port b enable; single-cycle pulse.
- web  out  1  RAM port b write select.
- addrb  out  ADDR_W  RAM address; held stable from the enb cycle until dob_valid is seen.
- dib  out  DATA_W  RAM write data.
- dob  in  DATA_W  RAM read data.
- dob_valid  in  1  RAM completion pulse.

Behaviour:
- Reset: all outputs 0 except req_ready=1; state=IDLE; timeout counter=0; captured request cleared. Reset mid-operation aborts immediately, with no response. The RAM is reset by the same rst_n.
- States: IDLE, RD_ISSUE, RD_WAIT, MODIFY, WR_ISSUE, WR_WAIT, RESP.
- IDLE: on req_valid && req_ready, latch op, addr and data.
  - addr >= DEPTH: go to RESP with rsp_err=1, rsp_data=0; no RAM access.
  - WRITE: go to WR_ISSUE.
  - Otherwise: go to RD_ISSUE.
- RD_ISSUE: enb=1, web=0, addrb=addr for one cycle; go to RD_WAIT.
- RD_WAIT: enb=0, addrb held. On dob_valid, capture dob.
  - READ: go to RESP.
  - INC/DEC: go to MODIFY.
- MODIFY: compute the new value with a saturating ±1.
  - On saturation: set rsp_sat, skip the write, go to RESP with the unchanged value.
  - Otherwise: go to WR_ISSUE.
- WR_ISSUE: enb=1, web=1, dib=value for one cycle; go to WR_WAIT.
- WR_WAIT: addrb, web and dib held; go to RESP on dob_valid. The dob value is ignored.
- RESP: rsp_valid=1 for exactly one cycle; rsp_data, rsp_err and rsp_sat valid in that cycle, 0 otherwise; go to IDLE.
- Timeout: the counter counts in RD_WAIT and WR_WAIT and clears on each ISSUE. When it reaches TIMEOUT without dob_valid: go to RESP with rsp_err=1, rsp_data=0. A later stray dob_valid is ignored in IDLE.
- Latency, with the request accepted in cycle 0 and the RAM answering in its nominal 3 cycles:
  - READ or WRITE: dob_valid seen in cycle 4; rsp_valid in cycle 5.
  - INC/DEC with no saturation: write issued in cycle 6; rsp_valid in cycle 10.
  - INC/DEC with saturation: rsp_valid in cycle 6.
  - Out-of-range: rsp_valid in cycle 1.
- Spacing: at least one cycle between a dob_valid and the next enb, which is guaranteed by MODIFY/RESP; this respects the RAM's post-access wait state.
- No response backpressure. req_ready is 0 from acceptance through RESP.

Decomposition:
- Shared package ram4_pkg holds:
  - op encodings OP_READ/OP_WRITE/OP_INC/OP_DEC;
  - the state enum;
  - constants RAM4_DEPTH=2140, RAM4_ADDR_W=12, RAM4_DATA_W=4.
- One sub-module: sat_addsub4, combinational 4-bit saturating ±1 with a sat flag.

Test Plan:
- WRITE addr 100 data 7, then READ addr 100 -> each rsp_valid 5 cycles after acceptance; READ rsp_data=7, rsp_err=0.
- INC addr 100 (holds 7) -> rsp_valid 10 cycles after acceptance, rsp_data=8, rsp_sat=0; a subsequent READ returns 8.
- WRITE addr 5 data 15, then INC addr 5 -> rsp_data=15, rsp_sat=1, no write pulse (web never 1 during INC); DEC on a cell holding 0 -> rsp_data=0, rsp_sat=1.
- READ addr 2140 -> rsp_valid next cycle, rsp_err=1, enb never asserted.
- RAM model withholds dob_valid -> rsp_err=1, rsp_data=0 exactly TIMEOUT=15 wait cycles after RD_ISSUE; a late dob_valid produces no response.
- Assert rst_n during WR_WAIT of an INC -> all outputs return to reset values asynchronously; no rsp_valid; a fresh READ afterwards completes normally.
